// File: rtl/memory_bus_arbiter_if.sv
// rtl/memory_bus_arbiter_if.sv - core request ports and virtual memory bus shared by the arbiter
interface memory_bus_arbiter_if;
  logic        reqI;
  logic [31:0] addrI;
  logic [31:0] rdataI;
  logic        ackI;
  logic        reqD;
  logic [31:0] addrD;
  logic [31:0] wdataD;
  logic        weD;
  logic [31:0] rdataD;
  logic        ackD;
  logic [31:0] addressVirt;
  logic [31:0] dataInVirt;
  logic        wEnVirt;
  logic [31:0] dataOutVirt;
  logic [1:0]  grant;

  modport slave (
    input  reqI, addrI, reqD, addrD, wdataD, weD, dataOutVirt,
    output rdataI, ackI, rdataD, ackD, addressVirt, dataInVirt, wEnVirt, grant
  );

  modport master (
    output reqI, addrI, reqD, addrD, wdataD, weD, dataOutVirt,
    input  rdataI, ackI, rdataD, ackD, addressVirt, dataInVirt, wEnVirt, grant
  );
endinterface

// File: rtl/memory_bus_arbiter.sv
// rtl/memory_bus_arbiter.sv - two-port (fetch / load-store) arbiter for the virtual memory bus
// Define ARB_ROUND_ROBIN_EN for alternating tie priority; otherwise the data port wins ties.
module memory_bus_arbiter #(
  parameter int READ_LATENCY = 1
) (
  input logic                 clk,
  input logic                 rst,
  memory_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  localparam logic [1:0] LOAD_CNT = 2'(READ_LATENCY - 1);

  state_t     state;
  logic [1:0] cnt;
  logic       owner_d;
  logic       is_store;
  logic       pick_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;

  // On a tie the port not served by the previous grant wins.
  always_comb begin
    pick_d = bus.reqD && (!bus.reqI || !last_d);
  end
`else
  always_comb begin
    pick_d = bus.reqD;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      owner_d         <= 1'b0;
      is_store        <= 1'b0;
      bus.rdataI      <= '0;
      bus.rdataD      <= '0;
      bus.ackI        <= 1'b0;
      bus.ackD        <= 1'b0;
      bus.addressVirt <= '0;
      bus.dataInVirt  <= '0;
      bus.wEnVirt     <= 1'b0;
      bus.grant       <= 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
      last_d          <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bus.ackI <= 1'b0;
          bus.ackD <= 1'b0;
          if (bus.reqI || bus.reqD) begin
            state   <= ACCESS;
            owner_d <= pick_d;
            cnt     <= LOAD_CNT;
`ifdef ARB_ROUND_ROBIN_EN
            last_d  <= pick_d;
`endif
            if (pick_d) begin
              bus.addressVirt <= bus.addrD;
              bus.dataInVirt  <= bus.weD ? bus.wdataD : 32'h0;
              bus.wEnVirt     <= bus.weD;
              is_store        <= bus.weD;
              bus.grant       <= 2'b10;
            end else begin
              bus.addressVirt <= bus.addrI;
              bus.dataInVirt  <= '0;
              bus.wEnVirt     <= 1'b0;
              is_store        <= 1'b0;
              bus.grant       <= 2'b01;
            end
          end
        end
        ACCESS: begin
          // Stores take one bus cycle; loads wait out the RAM read latency.
          if (is_store || cnt == 2'd0) begin
            if (!is_store) begin
              if (owner_d) bus.rdataD <= bus.dataOutVirt;
              else         bus.rdataI <= bus.dataOutVirt;
            end
            bus.ackD        <= owner_d;
            bus.ackI        <= !owner_d;
            bus.addressVirt <= '0;
            bus.dataInVirt  <= '0;
            bus.wEnVirt     <= 1'b0;
            bus.grant       <= 2'b00;
            is_store        <= 1'b0;
            state           <= ACK;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        ACK: begin
          bus.ackI <= 1'b0;
          bus.ackD <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
